// File: rtl/demux_vr_n.sv
// demux_vr_n: 1-to-N valid/ready demultiplexer with a FIFO per output channel
module demux_vr_n #(
  parameter int DATA_W     = 10,
  parameter int N_OUT      = 4,
  parameter int SEL_W      = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int MODE       = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic                    in_ready,
  output logic [N_OUT-1:0]        out_valid,
  output logic [N_OUT*DATA_W-1:0] out_data,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT-1:0]        fifo_full,
  output logic [SEL_W-1:0]        rr_ptr,
  output logic                    err_sel
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_OUT);
  logic [SEL_W-1:0] dst;
  logic sel_bad, accept;
  logic [N_OUT-1:0] push, pop;
  assign dst = (MODE != 0) ? rr_ptr : in_sel;
  assign sel_bad = (MODE == 0) && ({1'b0, in_sel} >= N_LIM);
  assign accept = in_valid && in_ready;
  assign pop = out_valid & out_ready;
  // ready when the destination FIFO has room; out-of-range selects are always sunk
  always_comb begin
    in_ready = sel_bad;
    for (int i = 0; i < N_OUT; i++)
      if (dst == SEL_W'(i) && !fifo_full[i]) in_ready = 1'b1;
  end
  for (genvar g = 0; g < N_OUT; g++) begin : g_ch
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    assign push[g] = accept && !sel_bad && dst == SEL_W'(g);
    assign out_valid[g] = cnt != '0;
    assign fifo_full[g] = cnt == DEPTH;
    // when empty, the slot behind the read pointer still holds the last popped word
    assign out_data[g*DATA_W +: DATA_W] = (cnt == '0) ? mem[rp - PW'(1)] : mem[rp];
    // channel FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
      if (reset) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
      end else begin
        if (push[g]) begin
          mem[wp] <= in_data;
          wp <= wp + PW'(1);
        end
        if (pop[g]) rp <= rp + PW'(1);
        cnt <= cnt + CW'(push[g]) - CW'(pop[g]);
      end
    end
  end
  // round-robin destination advances on every accepted word
  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= '0;
    else if (MODE != 0 && accept) rr_ptr <= (rr_ptr == SEL_W'(N_OUT - 1)) ? '0 : rr_ptr + SEL_W'(1);
  end
  // sticky flag for accepted words with an out-of-range select
  always_ff @(posedge clk) begin
    if (reset) err_sel <= 1'b0;
    else if (accept && sel_bad) err_sel <= 1'b1;
  end
endmodule

// File: tb/tb_demux_vr_n.sv
// tb_demux_vr_n: scoreboard bench for a 3-channel select-mode and a 4-channel round-robin demux
module tb_demux_vr_n;
  logic clk = 1'b0;
  logic reset;
  logic va, vb, ra_dut, rb_dut, err_a, err_b;
  logic [9:0] da, db;
  logic [1:0] sa, sb, rr_a, rr_b;
  logic [2:0] ova, ora, ffa;
  logic [3:0] ovb, orb, ffb;
  logic [29:0] oda;
  logic [39:0] odb;
  int n_vec = 0, n_err = 0;
  int qa [3][$];
  int qb [4][$];
  int cnt_a [3];
  int cnt_b [4];
  int rr_m = 0;
  bit err_m = 0;

  always #5 clk = ~clk;

  demux_vr_n #(.DATA_W(10), .N_OUT(3), .SEL_W(2), .FIFO_DEPTH(2), .MODE(0)) u_a (
    .clk(clk), .reset(reset), .in_valid(va), .in_data(da), .in_sel(sa), .in_ready(ra_dut),
    .out_valid(ova), .out_data(oda), .out_ready(ora), .fifo_full(ffa), .rr_ptr(rr_a), .err_sel(err_a));

  demux_vr_n #(.DATA_W(10), .N_OUT(4), .SEL_W(2), .FIFO_DEPTH(2), .MODE(1)) u_b (
    .clk(clk), .reset(reset), .in_valid(vb), .in_data(db), .in_sel(sb), .in_ready(rb_dut),
    .out_valid(ovb), .out_data(odb), .out_ready(orb), .fifo_full(ffb), .rr_ptr(rr_b), .err_sel(err_b));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step(bit r, bit iva, int ida, int isa, int iora, bit ivb, int idb, int iorb);
    logic [2:0] ev_a, ef_a;
    logic [3:0] ev_b, ef_b;
    bit bad, er_a, er_b;
    @(negedge clk);
    reset = r;
    va = iva; da = 10'(ida); sa = 2'(isa); ora = 3'(iora);
    vb = ivb; db = 10'(idb); sb = 2'($urandom_range(0, 3)); orb = 4'(iorb);
    #1;
    for (int i = 0; i < 3; i++) begin ev_a[i] = cnt_a[i] > 0; ef_a[i] = cnt_a[i] == 2; end
    for (int i = 0; i < 4; i++) begin ev_b[i] = cnt_b[i] > 0; ef_b[i] = cnt_b[i] == 2; end
    bad = isa >= 3;
    er_a = bad || cnt_a[isa] < 2;
    er_b = cnt_b[rr_m] < 2;
    chk("a_valid", 32'(ova), 32'(ev_a));
    chk("a_full", 32'(ffa), 32'(ef_a));
    chk("a_ready", 32'(ra_dut), 32'(er_a));
    chk("a_err", 32'(err_a), 32'(err_m));
    chk("a_rr", 32'(rr_a), 0);
    chk("b_valid", 32'(ovb), 32'(ev_b));
    chk("b_full", 32'(ffb), 32'(ef_b));
    chk("b_ready", 32'(rb_dut), 32'(er_b));
    chk("b_rr", 32'(rr_b), 32'(rr_m));
    chk("b_err", 32'(err_b), 0);
    if (r) begin
      for (int i = 0; i < 3; i++) begin cnt_a[i] = 0; qa[i].delete(); end
      for (int i = 0; i < 4; i++) begin cnt_b[i] = 0; qb[i].delete(); end
      rr_m = 0;
      err_m = 0;
    end else begin
      for (int i = 0; i < 3; i++) if (cnt_a[i] > 0 && ora[i]) cnt_a[i]--;
      for (int i = 0; i < 4; i++) if (cnt_b[i] > 0 && orb[i]) cnt_b[i]--;
      if (iva && er_a) begin
        if (bad) err_m = 1;
        else begin qa[isa].push_back(ida & 'h3ff); cnt_a[isa]++; end
      end
      if (ivb && er_b) begin
        qb[rr_m].push_back(idb & 'h3ff);
        cnt_b[rr_m]++;
        rr_m = (rr_m + 1) % 4;
      end
    end
  endtask

  // monitor: every presented-and-taken head word is checked against its channel queue
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        for (int i = 0; i < 3; i++)
          if (ova[i] && ora[i]) chk("a_data", 32'(oda[i*10 +: 10]), qa[i].size() > 0 ? qa[i].pop_front() : 32'hffff_ffff);
        for (int i = 0; i < 4; i++)
          if (ovb[i] && orb[i]) chk("b_data", 32'(odb[i*10 +: 10]), qb[i].size() > 0 ? qb[i].pop_front() : 32'hffff_ffff);
      end
    end
  end

  initial begin
    reset = 1; va = 0; vb = 0; da = 0; db = 0; sa = 0; sb = 0; ora = 0; orb = 0;
    for (int i = 0; i < 3; i++) cnt_a[i] = 0;
    for (int i = 0; i < 4; i++) cnt_b[i] = 0;
    repeat (2) @(posedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 'h155, 2, 0, 1, 'h010, 'hf);
    step(0, 1, 'h001, 1, 0, 1, 'h011, 'hf);
    step(0, 1, 'h002, 1, 0, 1, 'h012, 'hf);
    step(0, 1, 'h003, 1, 0, 1, 'h013, 'hf);
    step(0, 1, 'h004, 0, 0, 1, 'h014, 'hf);
    step(0, 0, 0, 0, 'b010, 1, 'h015, 'hf);
    step(0, 0, 0, 0, 'b010, 0, 0, 'b1011);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 0, 1, 'h20 + k, 'b1011);
    step(0, 1, 'h005, 0, 'b001, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 'h007, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 'h0aa, 0, 0, 1, 'h0bb, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1023), $urandom_range(0, 3),
           $urandom_range(0, 7), $urandom_range(0, 3) != 0, $urandom_range(0, 1023), $urandom_range(0, 15));
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 'b111, 0, 0, 'hf);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
